// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions for the exception controller: FSM states, register
// indices, ExcCodes and Status/Cause bit positions.
package cp0_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_EPC,
    S_CAUSE,
    S_BADV,
    S_STATUS,
    S_ERET,
    S_FLUSH
  } state_e;

  // CP0 write indices are {reg, sel[2:0]}
  localparam logic [7:0]  CP0_BADV   = 8'd64;
  localparam logic [7:0]  CP0_STATUS = 8'd96;
  localparam logic [7:0]  CP0_CAUSE  = 8'd104;
  localparam logic [7:0]  CP0_EPC    = 8'd112;

  localparam logic [31:0] CP0_EXC_VEC = 32'hBFC0_0380;

  localparam logic [4:0]  EXC_INT  = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_SYS  = 5'd8;
  localparam logic [4:0]  EXC_BP   = 5'd9;
  localparam logic [4:0]  EXC_RI   = 5'd10;
  localparam logic [4:0]  EXC_OV   = 5'd12;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int IP_LO      = 8;
  localparam int IP_HI      = 15;

endpackage

// File: rtl/cp0_exc_ctrl.sv
// CP0 write-port sequencer: arbitrates exceptions, interrupts, ERET and MTC0.
// Define CP0_IRQ_EN to enable the interrupt detection term.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VEC     = CP0_EXC_VEC,
  parameter logic [7:0]  ADDR_BADV   = CP0_BADV,
  parameter logic [7:0]  ADDR_STATUS = CP0_STATUS,
  parameter logic [7:0]  ADDR_CAUSE  = CP0_CAUSE,
  parameter logic [7:0]  ADDR_EPC    = CP0_EPC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [4:0]  ex_code,
  input  logic        ex_bd,
  input  logic [31:0] ex_pc,
  input  logic        ex_has_badv,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret_valid,
  input  logic        mtc0_wen,
  input  logic [7:0]  mtc0_addr,
  input  logic [31:0] mtc0_wdata,
  input  logic [31:0] status_q,
  input  logic [31:0] cause_q,
  input  logic [31:0] epc_q,
  output logic        cp0_wen,
  output logic [7:0]  cp0_addr,
  output logic [31:0] cp0_wdata,
  output logic        busy,
  output logic        flush,
  output logic [31:0] flush_pc
);

  state_e      state_q;
  logic [4:0]  code_q;
  logic        bd_q;
  logic [31:0] pc_q;
  logic        has_badv_q;
  logic [31:0] badv_q;
  logic        exl_was_q;
  logic        eret_q;
  logic [31:0] epc_lat_q;
  logic        irq;
  logic [31:0] cause_wr;

`ifdef CP0_IRQ_EN
  assign irq = (|(cause_q[IP_HI:IP_LO] & status_q[IP_HI:IP_LO]))
             & status_q[STATUS_IE] & ~status_q[STATUS_EXL];
`else
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      code_q     <= '0;
      bd_q       <= 1'b0;
      pc_q       <= '0;
      has_badv_q <= 1'b0;
      badv_q     <= '0;
      exl_was_q  <= 1'b0;
      eret_q     <= 1'b0;
      epc_lat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (irq || ex_valid) begin
            // An interrupt rides on the committing instruction's PC/BD slot
            code_q     <= irq ? EXC_INT : ex_code;
            bd_q       <= ex_bd;
            pc_q       <= ex_pc;
            has_badv_q <= irq ? 1'b0 : ex_has_badv;
            badv_q     <= ex_badvaddr;
            exl_was_q  <= status_q[STATUS_EXL];
            eret_q     <= 1'b0;
            state_q    <= status_q[STATUS_EXL] ? S_CAUSE : S_EPC;
          end else if (eret_valid) begin
            eret_q  <= 1'b1;
            state_q <= S_ERET;
          end
        end
        S_EPC:    state_q <= S_CAUSE;
        S_CAUSE:  state_q <= has_badv_q ? S_BADV : S_STATUS;
        S_BADV:   state_q <= S_STATUS;
        S_STATUS: state_q <= S_FLUSH;
        S_ERET: begin
          epc_lat_q <= epc_q;
          state_q   <= S_FLUSH;
        end
        S_FLUSH:  state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // BD is only refreshed when the exception is not nested inside EXL
  always_comb begin
    cause_wr           = cause_q;
    cause_wr[6:2]      = code_q;
    cause_wr[CAUSE_BD] = exl_was_q ? cause_q[CAUSE_BD] : bd_q;
  end

  always_comb begin
    cp0_wen   = 1'b0;
    cp0_addr  = '0;
    cp0_wdata = '0;
    busy      = 1'b0;
    flush     = 1'b0;
    flush_pc  = '0;
    if (resetn) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (mtc0_wen && !irq && !ex_valid && !eret_valid) begin
            cp0_wen   = 1'b1;
            cp0_addr  = mtc0_addr;
            cp0_wdata = mtc0_wdata;
          end
        end
        S_EPC: begin
          cp0_wen   = 1'b1;
          cp0_addr  = ADDR_EPC;
          cp0_wdata = bd_q ? (pc_q - 32'd4) : pc_q;
        end
        S_CAUSE: begin
          cp0_wen   = 1'b1;
          cp0_addr  = ADDR_CAUSE;
          cp0_wdata = cause_wr;
        end
        S_BADV: begin
          cp0_wen   = 1'b1;
          cp0_addr  = ADDR_BADV;
          cp0_wdata = badv_q;
        end
        S_STATUS: begin
          cp0_wen   = 1'b1;
          cp0_addr  = ADDR_STATUS;
          cp0_wdata = status_q | 32'h2;
        end
        S_ERET: begin
          cp0_wen   = 1'b1;
          cp0_addr  = ADDR_STATUS;
          cp0_wdata = status_q & ~32'h2;
        end
        S_FLUSH: begin
          flush    = 1'b1;
          flush_pc = eret_q ? epc_lat_q : EXC_VEC;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed cases plus random events
// checked against a per-event list of expected CP0 writes and flush target.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [4:0]  ex_code;
  logic        ex_bd;
  logic [31:0] ex_pc;
  logic        ex_has_badv;
  logic [31:0] ex_badvaddr;
  logic        eret_valid;
  logic        mtc0_wen;
  logic [7:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [31:0] status_q;
  logic [31:0] cause_q;
  logic [31:0] epc_q;
  logic        cp0_wen;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        busy;
  logic        flush;
  logic [31:0] flush_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected per-cycle behaviour after an accepted event
  logic        e_wen  [16];
  logic [7:0]  e_addr [16];
  logic [31:0] e_data [16];
  logic        e_fl   [16];
  logic [31:0] e_fpc  [16];
  int          n_exp;

  cp0_exc_ctrl dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_code(ex_code), .ex_bd(ex_bd), .ex_pc(ex_pc),
    .ex_has_badv(ex_has_badv), .ex_badvaddr(ex_badvaddr),
    .eret_valid(eret_valid),
    .mtc0_wen(mtc0_wen), .mtc0_addr(mtc0_addr), .mtc0_wdata(mtc0_wdata),
    .status_q(status_q), .cause_q(cause_q), .epc_q(epc_q),
    .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .busy(busy), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
    e_wen[n_exp] = 1'b1; e_addr[n_exp] = a; e_data[n_exp] = d;
    e_fl[n_exp] = 1'b0; e_fpc[n_exp] = 32'h0;
    n_exp++;
  endtask

  task automatic push_flush(input logic [31:0] pc);
    e_wen[n_exp] = 1'b0; e_addr[n_exp] = 8'h0; e_data[n_exp] = 32'h0;
    e_fl[n_exp] = 1'b1; e_fpc[n_exp] = pc;
    n_exp++;
  endtask

  // Reference: the ordered CP0 update an exception must produce
  task automatic model_exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                           input logic hb, input logic [31:0] bv,
                           input logic [31:0] st, input logic [31:0] ca);
    logic [31:0] cnew;
    n_exp = 0;
    if (st[1] == 1'b0) push_wr(8'd112, bd ? pc - 32'd4 : pc);
    cnew = ca;
    cnew[6:2] = code;
    if (st[1] == 1'b0) cnew[31] = bd;
    push_wr(8'd104, cnew);
    if (hb) push_wr(8'd64, bv);
    push_wr(8'd96, st | 32'h2);
    push_flush(32'hBFC00380);
  endtask

  task automatic model_eret(input logic [31:0] st, input logic [31:0] ep);
    n_exp = 0;
    push_wr(8'd96, st & ~32'h2);
    push_flush(ep);
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_code = 0; ex_bd = 0; ex_pc = 0; ex_has_badv = 0; ex_badvaddr = 0;
    eret_valid = 0; mtc0_wen = 0; mtc0_addr = 0; mtc0_wdata = 0;
  endtask

  task automatic run_event(input string tag,
                           input logic exv, input logic [4:0] code, input logic bd,
                           input logic [31:0] pc, input logic hb, input logic [31:0] bv,
                           input logic erv, input logic mw, input logic [7:0] ma,
                           input logic [31:0] md, input logic [31:0] st,
                           input logic [31:0] ca, input logic [31:0] ep);
    logic irq;
    logic accepted;
    @(negedge clk);
    ex_valid = exv; ex_code = code; ex_bd = bd; ex_pc = pc;
    ex_has_badv = hb; ex_badvaddr = bv; eret_valid = erv;
    mtc0_wen = mw; mtc0_addr = ma; mtc0_wdata = md;
    status_q = st; cause_q = ca; epc_q = ep;
`ifdef CP0_IRQ_EN
    irq = ((ca[15:8] & st[15:8]) != 8'h0) && st[0] && !st[1];
`else
    irq = 1'b0;
`endif
    accepted = irq || exv || erv;
    n_exp = 0;
    if (irq) model_exc(5'd0, bd, pc, 1'b0, bv, st, ca);
    else if (exv) model_exc(code, bd, pc, hb, bv, st, ca);
    else if (erv) model_eret(st, ep);
    #1;
    chk({tag, ".acc_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, ".acc_flush"}, {31'h0, flush}, 32'h0);
    if (accepted) begin
      chk({tag, ".acc_wen"}, {31'h0, cp0_wen}, 32'h0);
    end else begin
      chk({tag, ".pt_wen"}, {31'h0, cp0_wen}, {31'h0, mw});
      if (mw) begin
        chk({tag, ".pt_addr"}, {24'h0, cp0_addr}, {24'h0, ma});
        chk({tag, ".pt_data"}, cp0_wdata, md);
      end
    end
    $display("event %s: exv=%0d irq=%0d erv=%0d mtc0=%0d st=%h ca=%h expected_cycles=%0d",
             tag, exv, irq, erv, mw, st, ca, n_exp);
    @(posedge clk); #1;
    for (int i = 0; i < n_exp; i++) begin
      // Junk on event inputs must be ignored while busy
      ex_valid = 1'($urandom); eret_valid = 1'($urandom); ex_code = 5'($urandom);
      ex_has_badv = 1'($urandom); ex_pc = $urandom; ex_bd = 1'($urandom);
      mtc0_wen = 1'b1; mtc0_addr = 8'($urandom); mtc0_wdata = $urandom;
      @(negedge clk);
      chk($sformatf("%s.c%0d_busy", tag, i + 1), {31'h0, busy}, 32'h1);
      chk($sformatf("%s.c%0d_wen", tag, i + 1), {31'h0, cp0_wen}, {31'h0, e_wen[i]});
      chk($sformatf("%s.c%0d_flush", tag, i + 1), {31'h0, flush}, {31'h0, e_fl[i]});
      if (e_wen[i]) begin
        chk($sformatf("%s.c%0d_addr", tag, i + 1), {24'h0, cp0_addr}, {24'h0, e_addr[i]});
        chk($sformatf("%s.c%0d_data", tag, i + 1), cp0_wdata, e_data[i]);
      end
      if (e_fl[i]) chk($sformatf("%s.c%0d_fpc", tag, i + 1), flush_pc, e_fpc[i]);
      @(posedge clk); #1;
    end
    clear_inputs();
    if (accepted) begin
      @(negedge clk);
      chk({tag, ".end_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, ".end_flush"}, {31'h0, flush}, 32'h0);
      chk({tag, ".end_wen"}, {31'h0, cp0_wen}, 32'h0);
    end
  endtask

  initial begin
    clear_inputs();
    status_q = 0; cause_q = 0; epc_q = 0;
    resetn = 0;
    mtc0_wen = 1'b1; mtc0_addr = 8'd96; mtc0_wdata = 32'h1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.wen", {31'h0, cp0_wen}, 32'h0);
    chk("reset.busy", {31'h0, busy}, 32'h0);
    chk("reset.flush", {31'h0, flush}, 32'h0);
    chk("reset.flush_pc", flush_pc, 32'h0);
    chk("reset.addr", {24'h0, cp0_addr}, 32'h0);
    clear_inputs();
    @(posedge clk); #1;
    resetn = 1;

    // Directed cases
    run_event("mtc0", 0, 0, 0, 0, 0, 0, 0, 1, 8'd96, 32'h0000FF01, 32'h0, 32'h0, 32'h0);
    run_event("exc_ov_bd", 1, 5'd12, 1, 32'h80001004, 0, 0, 0, 1, 8'd96, 32'hDEAD,
              32'h0, 32'h0, 32'h0);
    run_event("exc_adel_badv", 1, 5'd4, 0, 32'h80000100, 1, 32'h00000003, 0, 0, 0, 0,
              32'h0, 32'h0, 32'h0);
    run_event("exc_nested", 1, 5'd8, 0, 32'h80000200, 0, 0, 0, 0, 0, 0,
              32'h0000_0002, 32'h8000_0000, 32'h0);
    run_event("exc_pc_wrap", 1, 5'd10, 1, 32'h00000000, 0, 0, 0, 0, 0, 0,
              32'h0, 32'h7FFF_FF83, 32'h0);
    run_event("eret", 0, 0, 0, 0, 0, 0, 1, 1, 8'd112, 32'h5555, 32'h3, 32'h0, 32'h80002000);
    run_event("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
`ifdef CP0_IRQ_EN
    run_event("irq", 0, 5'd12, 0, 32'h80003000, 1, 32'h44, 1, 1, 8'd96, 32'h1,
              32'h401, 32'h400, 32'h0);
`endif

    // Reset during S_CAUSE: no further writes, no flush
    @(negedge clk);
    ex_valid = 1; ex_code = 5'd12; ex_pc = 32'h80004000; status_q = 0; cause_q = 0;
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    resetn = 0;
    @(negedge clk);
    chk("rst_mid.wen", {31'h0, cp0_wen}, 32'h0);
    chk("rst_mid.flush", {31'h0, flush}, 32'h0);
    @(posedge clk); #1;
    resetn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid.after%0d_busy", i), {31'h0, busy}, 32'h0);
      chk($sformatf("rst_mid.after%0d_flush", i), {31'h0, flush}, 32'h0);
      chk($sformatf("rst_mid.after%0d_wen", i), {31'h0, cp0_wen}, 32'h0);
    end
    $display("event rst_mid: reset asserted in S_CAUSE");

    // Random events
    for (int k = 0; k < 60; k++) begin
      run_event($sformatf("rnd%0d", k),
                ($urandom_range(0, 2) == 0), 5'($urandom), 1'($urandom), $urandom,
                1'($urandom), $urandom,
                ($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom), $urandom,
                $urandom & 32'h0000_FF03, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Sequencer that owns the single write port of the CP0 register file.
- Arbitrates among exceptions, interrupts, ERET and pipeline MTC0 writes.
- For an exception, performs the ordered multi-cycle CP0 update (EPC, Cause, BadVAddr, Status), then issues a pipeline flush and redirect.
- Sits between the writeback/commit stage and the CP0 register file.

Parameters:
- EXC_VEC, 32'hBFC00380, exception entry PC.
- ADDR_BADV, 8'd64, CP0 index of BadVAddr, {reg 8, sel 0}.
- ADDR_STATUS, 8'd96, CP0 index of Status, {12, 0}.
- ADDR_CAUSE, 8'd104, CP0 index of Cause, {13, 0}.
- ADDR_EPC, 8'd112, CP0 index of EPC, {14, 0}.

Ports:
- clk in 1: clock.
- resetn in 1: synchronous, active-low reset.
- ex_valid in 1: committing instruction raised an exception.
- ex_code in 5: ExcCode of that exception.
- ex_bd in 1: instruction is in a branch delay slot.
- ex_pc in 32: PC of the excepting instruction.
- ex_has_badv in 1: BadVAddr must be written.
- ex_badvaddr in 32: faulting address.
- eret_valid in 1: committing ERET.
- mtc0_wen in 1: pipeline MTC0 write request.
- mtc0_addr in 8: MTC0 target index.
- mtc0_wdata in 32: MTC0 data.
- status_q in 32: current Status value.
- cause_q in 32: current Cause value.
- epc_q in 32: current EPC value.
- cp0_wen out 1: CP0 write enable.
- cp0_addr out 8: CP0 write index.
- cp0_wdata out 32: CP0 write data.
- busy out 1: stall the pipeline.
- flush out 1: one-cycle flush pulse.
- flush_pc out 32: redirect target, valid while flush=1.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, all latched fields cleared. All outputs are 0 and flush_pc=0.
- States: IDLE, S_EPC, S_CAUSE, S_BADV, S_STATUS, S_ERET, S_FLUSH.
- Event priority in IDLE: interrupt > ex_valid > eret_valid > mtc0_wen. Only one event is accepted per cycle; lower-priority events in that cycle are dropped, because the pipeline is being flushed.
- MTC0 in IDLE with no other event: combinational pass-through.
  - cp0_wen=mtc0_wen, cp0_addr=mtc0_addr, cp0_wdata=mtc0_wdata.
  - Zero latency; state stays IDLE.
- Exception accept (IDLE):
  - Latch code, bd, pc, has_badv, badvaddr, and exl_was=status_q[1].
  - busy=1 from the next cycle.
  - Next state: S_EPC if exl_was=0, else S_CAUSE. EPC is not overwritten when EXL is already set.
- S_EPC: write ADDR_EPC with (bd ? pc-32'd4 : pc), 32-bit wrap. Go to S_CAUSE.
- S_CAUSE: write ADDR_CAUSE with cause_q modified as follows, all other bits preserved:
  - bits[6:2]=code.
  - bit31=bd if exl_was=0, else cause_q[31].
  - Next state: S_BADV if has_badv, else S_STATUS.
- S_BADV: write ADDR_BADV with badvaddr. Go to S_STATUS.
- S_STATUS: write ADDR_STATUS with status_q | 32'h2 (set EXL). Go to S_FLUSH.
- S_FLUSH: flush=1 and flush_pc=EXC_VEC for exactly one cycle, cp0_wen=0. Go to IDLE.
- ERET accept (IDLE):
  - Go to S_ERET, busy=1.
  - S_ERET writes ADDR_STATUS with status_q & ~32'h2 and latches epc_q.
  - Then S_FLUSH with flush_pc=latched EPC.
- busy=1 in every state except IDLE. MTC0 and new exception/ERET inputs are ignored while busy.
- cp0_wen=1 exactly one cycle in each write state. Latency from accept to flush pulse: 4 cycles (EXL=0, no BadVAddr), 5 with BadVAddr, 3 with EXL=1, 2 for ERET.
- Reset mid-sequence aborts to IDLE with no further writes and no flush.

Optional Feature:
- CP0_IRQ_EN defined:
  - In IDLE, interrupt = |(cause_q[15:8] & status_q[15:8]) & status_q[0] & ~status_q[1].
  - It is handled as an exception with code 5'd0, bd=ex_bd, pc=ex_pc, no BadVAddr.
  - It takes precedence over ex_valid.
- Undefined: the interrupt term is constant 0 and no interrupt logic is synthesised.

Decomposition:
- Shared package cp0_pkg holds:
  - State enum.
  - CP0 index constants (BadVAddr/Status/Cause/EPC).
  - ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
  - Status/Cause bit positions (EXL=1, IE=0, BD=31, IP/IM 15:8).
- No sub-module; a single FSM with a write-mux is natural.

Test Plan:
- MTC0 in IDLE, addr=96, data=32'h0000FF01 → same cycle cp0_wen=1, addr=96, wdata=32'h0000FF01, busy=0.
- ex_valid, code=12, bd=1, pc=32'h80001004, status_q=0, cause_q=0:
  - Writes EPC=32'h80001000, then Cause=32'h80000030, then Status=32'h2.
  - Then flush=1, flush_pc=32'hBFC00380, 4 cycles after accept.
- ex_valid, code=4, has_badv=1, badvaddr=32'h00000003 → writes EPC, Cause bits[6:2]=4, BadVAddr=32'h3, Status; flush on cycle 5.
- ex_valid with status_q[1]=1, cause_q[31]=1 → no EPC write; Cause keeps bit31=1; flush on cycle 3.
- eret_valid, epc_q=32'h80002000, status_q=32'h3 → Status=32'h1, then flush_pc=32'h80002000; concurrent MTC0 is dropped.
- resetn=0 during S_CAUSE → next cycle IDLE, busy=0, no flush.
- With CP0_IRQ_EN: status_q=32'h401, cause_q=32'h400 → interrupt accepted, Cause ExcCode=0.
